// File: rtl/custom_float_to_int.sv
// Iterative custom-float to signed integer converter.
// Truncates toward zero, saturates on overflow, flags discarded fraction bits.
module custom_float_to_int #(
  parameter int MANT_LEN = 23,
  parameter int INT_LEN  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MANT_LEN+8:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INT_LEN-1:0]    out_data,
  output logic                  out_ovf,
  output logic                  out_inexact
);

  localparam int CW = $clog2(MANT_LEN + 1) + 1;
  localparam logic signed [9:0] EMAX = 10'(INT_LEN - 1);
  localparam logic signed [9:0] MLEN = 10'(MANT_LEN);
  localparam logic [INT_LEN-1:0] MAXV = {1'b0, {(INT_LEN-1){1'b1}}};
  localparam logic [INT_LEN-1:0] MINV = {1'b1, {(INT_LEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    SIGN,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [INT_LEN-1:0] mag_q, mag_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               sign_q, sign_d;
  logic               ovf_q, ovf_d;
  logic               inex_q, inex_d;
  logic [INT_LEN-1:0] data_q, data_d;
  logic               fovf_q, fovf_d;
  logic               finex_q, finex_d;

  logic                sgn;
  logic [7:0]          ex;
  logic [MANT_LEN-1:0] man;
  logic signed [9:0]   e_s;
  logic signed [9:0]   sh_s;
  logic [9:0]          n_abs;

  assign sgn   = in_data[MANT_LEN+8];
  assign ex    = in_data[MANT_LEN+7:MANT_LEN];
  assign man   = in_data[MANT_LEN-1:0];
  assign e_s   = $signed({2'b00, ex}) - 10'sd127;
  assign sh_s  = e_s - MLEN;
  assign n_abs = sh_s[9] ? 10'(-sh_s) : 10'(sh_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mag_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
      inex_q  <= 1'b0;
      data_q  <= '0;
      fovf_q  <= 1'b0;
      finex_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
      inex_q  <= inex_d;
      data_q  <= data_d;
      fovf_q  <= fovf_d;
      finex_q <= finex_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    inex_d  = inex_q;
    data_d  = data_q;
    fovf_d  = fovf_q;
    finex_d = finex_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = sgn;
          ovf_d   = 1'b0;
          inex_d  = 1'b0;
          mag_d   = '0;
          cnt_d   = '0;
          dir_d   = 1'b0;
          state_d = SIGN;
          if (ex == 8'h00) begin
            inex_d = |man;
          end else if (ex == 8'hFF || e_s > EMAX ||
                       (e_s == EMAX && !(sgn && man == '0))) begin
            ovf_d = 1'b1;
          end else if (e_s == EMAX) begin
            mag_d = MINV;
          end else if (e_s[9]) begin
            inex_d = 1'b1;
          end else begin
            mag_d = INT_LEN'({1'b1, man});
            dir_d = !sh_s[9];
            cnt_d = CW'(n_abs);
            if (n_abs != '0) state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (dir_q) begin
          mag_d = mag_q << 1;
        end else begin
          mag_d  = mag_q >> 1;
          inex_d = inex_q | mag_q[0];
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = SIGN;
      end
      SIGN: begin
        if (ovf_q) data_d = sign_q ? MINV : MAXV;
        else       data_d = sign_q ? -mag_q : mag_q;
        fovf_d  = ovf_q;
        finex_d = inex_q;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == IDLE);
    out_valid   = (state_q == DONE);
    out_data    = data_q;
    out_ovf     = fovf_q;
    out_inexact = finex_q;
  end

endmodule
